uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmit byte channel between `NREQ` on-chip requesters, so that several masters can print through the same UART. The channel is the TX data/valid path that the UART register block drives. A round-robin scheduler grants the channel to one requester for a whole message, delimited by `req_last`, so messages never interleave. A one-entry output register decouples requesters from UART back-pressure. An idle-timeout releases a grant held by a stalled requester.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `TIMEOUT`, 255: idle cycles allowed mid-message before the grant is revoked; legal range 1..65535.
- `IDW`, `$clog2(NREQ)`: width of the grant index (derived).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when 0, no new grant is issued.
- `req_valid` in NREQ: requester i has a byte.
- `req_data` in NREQ*8: byte of requester i in bits [8i+7:8i].
- `req_last` in NREQ: the byte from requester i ends its message.
- `req_ready` out NREQ: byte accepted from requester i.
- `tx_data` out 8: byte to the UART.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the UART accepts the byte this cycle.
- `grant_valid` out 1: a requester currently owns the channel.
- `grant_id` out IDW: index of the owner; holds its last value when `grant_valid`=0.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- **Reset values:** state=IDLE, `rr_ptr`=0, `grant_id`=0, `grant_valid`=0, `tx_valid`=0, `tx_data`=0x00, `timeout_pulse`=0, `req_ready`=0, idle counter=0.
- **IDLE state:**
  - If `enable` and any `req_valid` bit is set, pick the first set bit searching i = `rr_ptr`, `rr_ptr`+1, … modulo NREQ.
  - Register `grant_id`, set `grant_valid`=1, clear the idle counter, go to LOCK.
  - `req_ready` is all-zero in IDLE.
- **LOCK state:**
  - `req_ready[g]` = `!tx_valid || tx_ready`, where g = `grant_id`. All other bits are 0. This term is combinational from `tx_ready`.
  - A transfer occurs when `req_valid[g] && req_ready[g]`. On a transfer, `tx_data` <= byte, `tx_valid` <= 1, and the idle counter clears.
  - Transfer with `req_last[g]`=1: go to IDLE, `grant_valid` <= 0, `rr_ptr` <= (g+1) mod NREQ.
  - Cycle with `req_valid[g]`=0: the idle counter increments (saturating, 16 bits).
  - When the counter reaches `TIMEOUT`: go to IDLE, `grant_valid` <= 0, `rr_ptr` <= (g+1) mod NREQ, `timeout_pulse`=1 for one cycle. The counter then clears.
  - `req_valid[g]`=1 stalled by back-pressure does NOT count as idle.
- **Output register:**
  - `tx_valid` clears on `tx_ready` unless a new byte loads in the same cycle.
  - A load and a drain in the same cycle keep `tx_valid`=1 and replace the data.
  - `tx_data` holds its value when not loading.
- **`enable` deasserted:** the current message runs to `req_last` or timeout; IDLE then issues no grant until `enable`=1.
- **Requester drops `req_valid` mid-message:** the grant is held; only the timeout or `req_last` releases it.
- **Reset mid-message:** all state returns to reset values; a buffered byte is discarded.
- **Single-byte messages** (`req_last`=1 on the first byte) are legal.
- **NREQ not a power of two:** `rr_ptr` wraps from NREQ-1 to 0 explicitly.

## Timing
- Grant latency: `req_valid` sampled in IDLE at cycle n, LOCK and `req_ready` high at cycle n+1.
- Byte latency: a transfer at cycle k gives `tx_valid`=1 with that byte at cycle k+1.
- Throughput: 1 byte/cycle while `tx_ready`=1.
- Inter-message bubble: exactly one IDLE cycle between the `req_last` transfer and the next grant.
- `timeout_pulse` is asserted in the first IDLE cycle after the revocation.
- `grant_valid` and `grant_id` are registered; they change the cycle after the triggering event.

## Test plan
- **Single requester:** req1 sends 0x41, 0x42, 0x43 (`last` on 0x43), `tx_ready`=1.
  - `grant_id`=1 at cycle 1; `tx_data` sequence 0x41, 0x42, 0x43 on cycles 2-4; `grant_valid`=0 at cycle 4.
- **Round-robin:** req0 and req2 both hold 2-byte messages from reset.
  - Order is req0 then req2 (one bubble between them), `rr_ptr`=3.
  - A following req0 and req3 contest grants req3 first.
- **Back-pressure:** `tx_ready`=0 for 10 cycles with `tx_valid`=1.
  - `req_ready[g]`=0 and `tx_data` stable; no timeout even with `TIMEOUT`=4.
  - The byte drains on the first `tx_ready`=1, and the next byte loads the same cycle.
- **Timeout:** `TIMEOUT`=8; req2 sends 1 byte without `last`, then drops `req_valid`.
  - `timeout_pulse`=1 exactly 9 cycles after the transfer; `grant_valid`=0; pending req3 granted the next cycle.
- **Enable gating:** `enable`=0 while req1 is mid-message.
  - The message completes; req0 stays ungranted until `enable`=1, then is granted 1 cycle later.
- **Reset mid-message:** `rst`=1 for one cycle during LOCK with `tx_valid`=1.
  - Next cycle `tx_valid`=0, `grant_valid`=0, `rr_ptr`=0, `req_ready`=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART TX byte channel among NREQ
// requesters, with a one-entry output register and a mid-message idle timeout.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_pulse,
  output logic              state_dbg,
  output logic [IDW-1:0]    rr_ptr_dbg
);

  // Handshakes: a requester byte moves when req_valid[i] && req_ready[i]
  // (req_ready only ever high for the owner in LOCK); a UART byte moves when
  // tx_valid && tx_ready. Neither valid may depend on its ready.
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [15:0]    idle_cnt;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW:0]   scan_sum;
  logic           cur_valid, cur_last, slot_free, xfer, idle_cyc;
  logic           timeout_hit, grant_now, release_now;
  logic [7:0]     cur_data;
  logic [IDW-1:0] next_ptr;

  assign cur_valid   = req_valid[grant_id];
  assign cur_last    = req_last[grant_id];
  assign cur_data    = req_data[{grant_id, 3'b000} +: 8];
  assign slot_free   = !tx_valid || tx_ready;
  assign xfer        = (state == LOCK) && cur_valid && slot_free;
  assign idle_cyc    = (state == LOCK) && !cur_valid;
  // Revoke on the idle cycle that brings the count up to TIMEOUT.
  assign timeout_hit = idle_cyc && (({1'b0, idle_cnt} + 17'd1) >= 17'(TIMEOUT));
  assign grant_now   = (state == IDLE) && enable && pick_found;
  assign release_now = (xfer && cur_last) || timeout_hit;
  assign next_ptr    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  assign state_dbg   = state;
  assign rr_ptr_dbg  = rr_ptr;

  // Scan starting at rr_ptr, wrapping explicitly so non-power-of-two NREQ works.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) scan_sum = scan_sum - (IDW+1)'(NREQ);
      if (!pick_found && req_valid[scan_sum[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_now) state_nxt = LOCK;
      LOCK:    if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == LOCK) req_ready[grant_id] = slot_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      grant_valid   <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      timeout_pulse <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      timeout_pulse <= timeout_hit;
      if (grant_now) begin
        grant_id    <= pick_id;
        grant_valid <= 1'b1;
      end else if (release_now) begin
        grant_valid <= 1'b0;
        rr_ptr      <= next_ptr;
      end
      // A valid byte stalled by back-pressure holds the count rather than adding to it.
      if (grant_now || xfer || timeout_hit) idle_cnt <= '0;
      else if (idle_cyc && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
      if (xfer) begin
        tx_data  <= cur_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of per-cycle vectors plus hand-written
// back-pressure and timeout sequences.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic        clk, rst, enable, tx_ready;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_valid, grant_valid, timeout_pulse, state_dbg;
  logic [1:0]  grant_id, rr_ptr_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;   logic       en;  logic [3:0] rv;  logic [3:0] rl;
    logic       txr; logic [7:0] d;
    logic       gv;  logic [1:0] gid; logic       tv;  logic [7:0] td;
    logic [3:0] rdy; logic       tp;  logic [1:0] ptr;
  } vec_t;

  vec_t tbl[$];

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_pulse(timeout_pulse), .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  function automatic vec_t v(input logic r, en, input logic [3:0] rv, rl,
                             input logic txr, input logic [7:0] d,
                             input logic gv, input logic [1:0] gid, input logic tv,
                             input logic [7:0] td, input logic [3:0] rdy,
                             input logic tp, input logic [1:0] ptr);
    vec_t x;
    x.r = r; x.en = en; x.rv = rv; x.rl = rl; x.txr = txr; x.d = d;
    x.gv = gv; x.gid = gid; x.tv = tv; x.td = td; x.rdy = rdy; x.tp = tp; x.ptr = ptr;
    return x;
  endfunction

  // driver tasks
  task automatic drive(input logic r, en, input logic [3:0] rv, rl,
                       input logic txr, input logic [7:0] d);
    rst = r; enable = en; req_valid = rv; req_last = rl; tx_ready = txr;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = rv[i] ? d : 8'h5A;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int   n_hit;
  logic found;

  initial begin
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #2;

    // single requester: req1 sends 41 42 43
    tbl.push_back(v(0,1,4'b0010,4'b0000,1,8'h41, 0,2'd0,0,8'h00,4'b0000,0,2'd0));
    tbl.push_back(v(0,1,4'b0010,4'b0000,1,8'h41, 1,2'd1,0,8'h00,4'b0010,0,2'd0));
    tbl.push_back(v(0,1,4'b0010,4'b0000,1,8'h42, 1,2'd1,1,8'h41,4'b0010,0,2'd0));
    tbl.push_back(v(0,1,4'b0010,4'b0010,1,8'h43, 1,2'd1,1,8'h42,4'b0010,0,2'd0));
    tbl.push_back(v(0,1,4'b0000,4'b0000,1,8'h00, 0,2'd1,1,8'h43,4'b0000,0,2'd2));
    tbl.push_back(v(0,1,4'b0000,4'b0000,1,8'h00, 0,2'd1,0,8'h43,4'b0000,0,2'd2));
    tbl.push_back(v(1,1,4'b0000,4'b0000,1,8'h00, 0,2'd1,0,8'h43,4'b0000,0,2'd2));
    // round-robin: req0 and req2 two-byte messages, then req0 vs req3
    tbl.push_back(v(0,1,4'b0101,4'b0000,1,8'hA0, 0,2'd0,0,8'h00,4'b0000,0,2'd0));
    tbl.push_back(v(0,1,4'b0101,4'b0000,1,8'hA0, 1,2'd0,0,8'h00,4'b0001,0,2'd0));
    tbl.push_back(v(0,1,4'b0101,4'b0001,1,8'hA1, 1,2'd0,1,8'hA0,4'b0001,0,2'd0));
    tbl.push_back(v(0,1,4'b0100,4'b0000,1,8'hC0, 0,2'd0,1,8'hA1,4'b0000,0,2'd1));
    tbl.push_back(v(0,1,4'b0100,4'b0000,1,8'hC0, 1,2'd2,0,8'hA1,4'b0100,0,2'd1));
    tbl.push_back(v(0,1,4'b0100,4'b0100,1,8'hC1, 1,2'd2,1,8'hC0,4'b0100,0,2'd1));
    tbl.push_back(v(0,1,4'b1001,4'b0000,1,8'hD0, 0,2'd2,1,8'hC1,4'b0000,0,2'd3));
    tbl.push_back(v(0,1,4'b1001,4'b1000,1,8'hD0, 1,2'd3,0,8'hC1,4'b1000,0,2'd3));
    tbl.push_back(v(0,1,4'b0001,4'b0001,1,8'hE0, 0,2'd3,1,8'hD0,4'b0000,0,2'd0));
    tbl.push_back(v(0,1,4'b0001,4'b0001,1,8'hE0, 1,2'd0,0,8'hD0,4'b0001,0,2'd0));
    tbl.push_back(v(0,1,4'b0000,4'b0000,1,8'h00, 0,2'd0,1,8'hE0,4'b0000,0,2'd1));
    // enable gating: req1 mid-message when enable drops, req0 waits
    tbl.push_back(v(0,1,4'b0010,4'b0000,1,8'hB0, 0,2'd0,0,8'hE0,4'b0000,0,2'd1));
    tbl.push_back(v(0,0,4'b0010,4'b0000,1,8'hB0, 1,2'd1,0,8'hE0,4'b0010,0,2'd1));
    tbl.push_back(v(0,0,4'b0011,4'b0010,1,8'hB1, 1,2'd1,1,8'hB0,4'b0010,0,2'd1));
    tbl.push_back(v(0,0,4'b0001,4'b0000,1,8'hF0, 0,2'd1,1,8'hB1,4'b0000,0,2'd2));
    tbl.push_back(v(0,0,4'b0001,4'b0000,1,8'hF0, 0,2'd1,0,8'hB1,4'b0000,0,2'd2));
    tbl.push_back(v(0,1,4'b0001,4'b0000,1,8'hF0, 0,2'd1,0,8'hB1,4'b0000,0,2'd2));
    tbl.push_back(v(0,1,4'b0001,4'b0001,1,8'hF0, 1,2'd0,0,8'hB1,4'b0001,0,2'd2));
    tbl.push_back(v(0,1,4'b0000,4'b0000,1,8'h00, 0,2'd0,1,8'hF0,4'b0000,0,2'd1));
    // reset mid-message with a byte buffered
    tbl.push_back(v(0,1,4'b0100,4'b0000,1,8'h31, 0,2'd0,0,8'hF0,4'b0000,0,2'd1));
    tbl.push_back(v(0,1,4'b0100,4'b0000,1,8'h31, 1,2'd2,0,8'hF0,4'b0100,0,2'd1));
    tbl.push_back(v(1,1,4'b0100,4'b0000,1,8'h32, 1,2'd2,1,8'h31,4'b0100,0,2'd1));
    tbl.push_back(v(0,1,4'b0100,4'b0100,1,8'h33, 0,2'd0,0,8'h00,4'b0000,0,2'd0));
    tbl.push_back(v(0,1,4'b0100,4'b0100,1,8'h33, 1,2'd2,0,8'h00,4'b0100,0,2'd0));
    tbl.push_back(v(0,1,4'b0000,4'b0000,1,8'h00, 0,2'd2,1,8'h33,4'b0000,0,2'd3));
    tbl.push_back(v(0,1,4'b0000,4'b0000,1,8'h00, 0,2'd2,0,8'h33,4'b0000,0,2'd3));

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].en, tbl[n].rv, tbl[n].rl, tbl[n].txr, tbl[n].d);
      #1;
      chk($sformatf("row%0d grant_valid", n), 32'(grant_valid), 32'(tbl[n].gv));
      chk($sformatf("row%0d grant_id", n), 32'(grant_id), 32'(tbl[n].gid));
      chk($sformatf("row%0d tx_valid", n), 32'(tx_valid), 32'(tbl[n].tv));
      chk($sformatf("row%0d tx_data", n), 32'(tx_data), 32'(tbl[n].td));
      chk($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(tbl[n].rdy));
      chk($sformatf("row%0d timeout_pulse", n), 32'(timeout_pulse), 32'(tbl[n].tp));
      chk($sformatf("row%0d rr_ptr", n), 32'(rr_ptr_dbg), 32'(tbl[n].ptr));
      tick();
    end

    // back-pressure: req1 granted from rr_ptr=3, UART stalls for 10 cycles
    drive(0, 1, 4'b0010, 4'b0000, 1, 8'h61); #1; tick();
    drive(0, 1, 4'b0010, 4'b0000, 1, 8'h61); #1;
    chk("bp grant_id", 32'(grant_id), 32'd1);
    chk("bp first ready", 32'(req_ready), 32'b0010);
    tick();
    for (int s = 0; s < 10; s++) begin
      drive(0, 1, 4'b0010, 4'b0000, 0, 8'h62); #1;
      chk($sformatf("bp stall%0d ready", s), 32'(req_ready), 32'b0000);
      chk($sformatf("bp stall%0d tx_data", s), 32'(tx_data), 32'h61);
      chk($sformatf("bp stall%0d tx_valid", s), 32'(tx_valid), 32'd1);
      chk($sformatf("bp stall%0d no timeout", s), 32'(timeout_pulse | !grant_valid), 32'd0);
      tick();
    end
    drive(0, 1, 4'b0010, 4'b0000, 1, 8'h62); #1;
    chk("bp release ready", 32'(req_ready), 32'b0010);
    chk("bp release tx_data", 32'(tx_data), 32'h61);
    tick();
    drive(0, 1, 4'b0010, 4'b0010, 1, 8'h63); #1;
    chk("bp drain+load tx_data", 32'(tx_data), 32'h62);
    chk("bp drain+load tx_valid", 32'(tx_valid), 32'd1);
    tick();
    drive(0, 1, 4'b0000, 4'b0000, 1, 8'h00); #1;
    chk("bp last tx_data", 32'(tx_data), 32'h63);
    chk("bp release grant", 32'(grant_valid), 32'd0);
    chk("bp rr_ptr", 32'(rr_ptr_dbg), 32'd2);
    tick();

    // timeout: req2 sends one byte without last, then goes quiet; req3 waits
    drive(0, 1, 4'b0100, 4'b0000, 1, 8'h71); #1; tick();
    drive(0, 1, 4'b1100, 4'b0000, 1, 8'h71); #1;
    chk("to grant_id", 32'(grant_id), 32'd2);
    chk("to ready", 32'(req_ready), 32'b0100);
    tick();
    found = 1'b0;
    n_hit = 0;
    for (int n = 1; n <= 30 && !found; n++) begin
      drive(0, 1, 4'b1000, 4'b0000, 1, 8'h00); #1;
      if (timeout_pulse) begin
        found = 1'b1;
        n_hit = n;
      end else begin
        tick();
      end
    end
    chk("to pulse latency", 32'(n_hit), 32'd9);
    chk("to grant dropped", 32'(grant_valid), 32'd0);
    chk("to rr_ptr", 32'(rr_ptr_dbg), 32'd3);
    tick();
    chk("to pulse one cycle", 32'(timeout_pulse), 32'd0);
    chk("to next grant_valid", 32'(grant_valid), 32'd1);
    chk("to next grant_id", 32'(grant_id), 32'd3);
    chk("to next ready", 32'(req_ready), 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
